// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80-style IO bus master.
// The map-loader helper below is used only when MMU_MAP_LOADER_EN is defined.
package z80_bus_pkg;

    // Bus-cycle phases of one Z80 IN/OUT cycle
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TW   = 3'd3,
        ST_T3   = 3'd4
    } bus_state_t;

    localparam logic [7:0] IO_WIN    = 8'hD0;
    localparam logic [7:0] IO_BEEP   = 8'hD1;
    localparam logic [7:0] IO_MEMMAP = 8'hD8;

    // Page i of a packed 8 x 3-bit page map sits at bits 3i+2:3i
    function automatic logic [2:0] page_sel(input logic [23:0] pages, input logic [2:0] i);
        return pages[3*i +: 3];
    endfunction

endpackage

// File: rtl/mmu_map_loader.sv
// MMU map loader: replays the ten-cycle unlock / load-8-pages / lock sequence
// through the initiator's internal command mux. Built only with MMU_MAP_LOADER_EN.
`ifdef MMU_MAP_LOADER_EN
module mmu_map_loader
    import z80_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        map_start,
    input  logic [23:0] map_pages,
    input  logic        bus_idle,
    input  logic        cycle_end,
    input  logic        abort,
    output logic        ld_valid,
    output logic        ld_wr,
    output logic [7:0]  ld_addr,
    output logic [7:0]  ld_wdata,
    output logic        ld_busy,
    output logic        map_done
);

    localparam logic [3:0] LAST_IDX = 4'd10;

    logic        active;
    logic [3:0]  idx;
    logic [23:0] pages_q;
    logic        start;
    logic [3:0]  cur;
    logic [2:0]  pg;

    assign start    = map_start && bus_idle && !active;
    assign ld_valid = bus_idle && (start || (active && idx != LAST_IDX));
    assign ld_busy  = active || (map_start && bus_idle);

    // Decode the command for the step about to launch (step 0 launches on the start cycle)
    always_comb begin
        cur      = start ? 4'd0 : idx;
        pg       = 3'(cur - 4'd1);
        ld_wr    = 1'b1;
        ld_addr  = IO_BEEP;
        ld_wdata = 8'h00;
        if (cur == 4'd0) begin
            ld_wr = 1'b0;
        end else if (cur <= 4'd8) begin
            ld_addr  = IO_MEMMAP + {5'b0, pg};
            ld_wdata = {5'b0, page_sel(pages_q, pg)};
        end
    end

    // Sequence position, page snapshot and completion pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active   <= 1'b0;
            idx      <= 4'd0;
            pages_q  <= 24'd0;
            map_done <= 1'b0;
        end else begin
            map_done <= 1'b0;
            if (start) begin
                active  <= 1'b1;
                idx     <= 4'd1;
                pages_q <= map_pages;
            end else if (active) begin
                if (abort) begin
                    active <= 1'b0;
                    idx    <= 4'd0;
                end else if (ld_valid) begin
                    idx <= idx + 4'd1;
                end else if (cycle_end && idx == LAST_IDX) begin
                    active   <= 1'b0;
                    idx      <= 4'd0;
                    map_done <= 1'b1;
                end
            end
        end
    end

endmodule
`endif

// File: rtl/z80_io_initiator.sv
// Z80-style IO bus master: one IN/OUT cycle in flight, fed from a valid/ready
// command port. Defining MMU_MAP_LOADER_EN adds the map_start/map_pages/map_done
// ports and the built-in MMU map loading sequence.
//
// state   | meaning
// IDLE    | no cycle; cmd_ready high unless the map loader owns the bus
// T1      | address (and write data) driven, strobes high
// T2      | iorq plus rd or wr asserted
// TW      | WAIT_STATES fixed waits, then extended while wait_n low
// T3      | last strobe cycle; read data captured on the exit edge
module z80_io_initiator
    import z80_bus_pkg::*;
#(
    parameter int WAIT_STATES  = 1,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [7:0]  cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        err,
    output logic        iorq,
    output logic        rd,
    output logic        wr,
    output logic [7:0]  a07,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  data_in,
    input  logic        wait_n
`ifdef MMU_MAP_LOADER_EN
    ,
    input  logic        map_start,
    input  logic [23:0] map_pages,
    output logic        map_done
`endif
);

    localparam logic [2:0] WS_INIT  = 3'(WAIT_STATES - 1);
    localparam logic [7:0] TMO_INIT = 8'(WAIT_TIMEOUT - 1);

    bus_state_t state, state_nxt;

    logic       wr_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [2:0] wcnt;
    logic [7:0] tmo_cnt;
    logic       tmo_abort;
    logic       launch;
    logic       sel_wr;
    logic [7:0] sel_addr;
    logic [7:0] sel_wdata;

    logic       ld_valid;
    logic       ld_wr;
    logic [7:0] ld_addr;
    logic [7:0] ld_wdata;
    logic       ld_busy;

`ifdef MMU_MAP_LOADER_EN
    mmu_map_loader u_loader (
        .clk       (clk),
        .reset     (reset),
        .map_start (map_start),
        .map_pages (map_pages),
        .bus_idle  (state == ST_IDLE),
        .cycle_end (state == ST_T3),
        .abort     (tmo_abort),
        .ld_valid  (ld_valid),
        .ld_wr     (ld_wr),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_busy   (ld_busy),
        .map_done  (map_done)
    );
`else
    assign ld_valid = 1'b0;
    assign ld_wr    = 1'b0;
    assign ld_addr  = 8'h00;
    assign ld_wdata = 8'h00;
    assign ld_busy  = 1'b0;
`endif

    // The loader always wins the mux; host commands only launch when it is quiet
    assign sel_wr    = ld_valid ? ld_wr    : cmd_wr;
    assign sel_addr  = ld_valid ? ld_addr  : cmd_addr;
    assign sel_wdata = ld_valid ? ld_wdata : cmd_wdata;
    assign launch    = (state == ST_IDLE) && (ld_valid || (cmd_valid && cmd_ready));
    assign tmo_abort = (state == ST_TW) && !wait_n && (tmo_cnt == 8'd0);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (launch) state_nxt = ST_T1;
            ST_T1:   state_nxt = ST_T2;
            ST_T2:   state_nxt = ST_TW;
            ST_TW: begin
                if (tmo_abort)         state_nxt = ST_IDLE;
                else if (wcnt != 3'd0) state_nxt = ST_TW;
                else if (!wait_n)      state_nxt = ST_TW;
                else                   state_nxt = ST_T3;
            end
            ST_T3:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus outputs decoded from state; strobes and drive enable release as soon as IDLE is entered
    always_comb begin
        iorq      = 1'b1;
        rd        = 1'b1;
        wr        = 1'b1;
        a07       = 8'h00;
        data_oe   = 1'b0;
        data_out  = 8'h00;
        cmd_ready = 1'b0;
        case (state)
            ST_IDLE: cmd_ready = !ld_busy;
            ST_T1: begin
                a07      = addr_q;
                data_oe  = wr_q;
                data_out = wr_q ? wdata_q : 8'h00;
            end
            ST_T2, ST_TW, ST_T3: begin
                a07      = addr_q;
                data_oe  = wr_q;
                data_out = wr_q ? wdata_q : 8'h00;
                iorq     = 1'b0;
                rd       = wr_q;
                wr       = !wr_q;
            end
            default: ;
        endcase
    end

    // Command latch, read capture and one-cycle response/error pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q      <= 1'b0;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            err       <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            err       <= 1'b0;
            if (launch) begin
                wr_q    <= sel_wr;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (state == ST_T3 && !wr_q) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= data_in;
            end
            if (tmo_abort) err <= 1'b1;
        end
    end

    // Wait-state and timeout down-counters, both armed in T2
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt    <= 3'd0;
            tmo_cnt <= 8'd0;
        end else begin
            case (state)
                ST_T2: begin
                    wcnt    <= WS_INIT;
                    tmo_cnt <= TMO_INIT;
                end
                ST_TW: begin
                    if (wcnt != 3'd0) wcnt <= wcnt - 3'd1;
                    if (wait_n)                tmo_cnt <= TMO_INIT;
                    else if (tmo_cnt != 8'd0)  tmo_cnt <= tmo_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
